key_sw_io_device: RTL and testbench

- Memory-mapped input device for the board's pushbuttons (KEY) and slide switches (SW).
- Sits directly downstream of the memory stage: it decodes the stage's address, write-data, and store/load strobes, and returns read data in the same cycle for the write-back register.
- Each input bit is synchronized and debounced.
- Change events are captured in sticky Ready/Overrun status bits, with per-device interrupt enables and a combined irq output.

---
 rtl/key_sw_io_device.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_key_sw_io_device.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sw_io_device.sv
// ---------------------------------------------------------------------------
// key_sw_io_device
//
// Memory-mapped input device for the board pushbuttons (KEY) and slide
// switches (SW). It sits right after the memory stage: it decodes the access
// address, store data and load/store strobes, and returns read data
// combinationally so the write-back register can capture it in the same cycle.
//
// Every raw input bit goes through a two-flop synchronizer and a debouncer.
// When any debounced bit of a device changes, that device's sticky Ready bit
// is set. If Ready is already set and is not being cleared on the same edge,
// the sticky Overrun bit is set as well. Each device has an interrupt enable,
// and irq is the OR of the two enabled Ready bits.
//
// Register map (offsets set by parameters):
//   ADDR_KEY   KDATA  {0, kStable[3:0]}   1 = pressed; a load clears KEY Ready
//   ADDR_SW    SDATA  {0, sStable[9:0]}   a load clears SW Ready
//   ADDR_KCTRL KCTRL  bit0 Ready (RO), bit2 Overrun (write 0 clears),
//                     bit4 IE (RW), all other bits read 0
//   ADDR_SCTRL SCTRL  same layout as KCTRL, for the switches
//   Any other address reads 0. Stores to KDATA/SDATA are ignored.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-low reset
//   addr     access address from the memory stage
//   wr_data  store data
//   wr_en    store strobe, one cycle per store
//   rd_en    load strobe, one cycle per load
//   rd_data  read data, combinational from addr
//   KEY      raw pushbuttons, active-low (0 = pressed)
//   SW       raw slide switches, active-high
//   irq      (kReady & kIe) | (sReady & sIe)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// key_sw_io_device_debounce
//
// One input bit: two-flop synchronizer followed by a counter debouncer.
// The counter runs while the synchronized level differs from the stable
// level and clears as soon as they agree again. On the edge where the count
// would reach DEBOUNCE_CYCLES the stable level is taken over and the counter
// clears. A raw change just before edge 1 therefore appears on stable at
// edge 2 + DEBOUNCE_CYCLES.
//
// Ports:
//   clk     system clock
//   reset   asynchronous, active-low reset
//   rawIn   unsynchronized input pin
//   stable  debounced level (after optional inversion), resets to 0
//   flip    high in the cycle whose closing edge updates stable
// ---------------------------------------------------------------------------
module key_sw_io_device_debounce #(
    parameter int   DEBOUNCE_CYCLES = 255,
    parameter logic RESET_LEVEL     = 1'b0,  // synchronizer reset value
    parameter logic INVERT          = 1'b0   // 1: stable = ~pin level
) (
    input  logic clk,
    input  logic reset,
    input  logic rawIn,
    output logic stable,
    output logic flip
);

    // The counter only ever holds 0 .. DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;

    // The synchronizer keeps the pin polarity so that its reset value
    // matches the idle state of the pin; inversion happens afterwards.
    assign level = INVERT ? ~sync2 : sync2;

    // Every update of stable is a real change, because the counter only
    // advances while level and stable disagree.
    assign flip = (level != stable) && (count == LAST_COUNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= RESET_LEVEL;
            sync2  <= RESET_LEVEL;
            count  <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= rawIn;
            sync2 <= sync1;
            if (level == stable) begin
                count <= '0;
            end else if (flip) begin
                stable <= level;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

module key_sw_io_device #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF000_0010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF000_0014,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF000_0110,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF000_0114,
    parameter int               DEBOUNCE_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [DBITS-1:0] rd_data,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic             irq
);

    localparam int KEY_BITS = 4;
    localparam int SW_BITS  = 10;

    // Debounced state and per-bit "updates on this edge" flags.
    logic [KEY_BITS-1:0] kStable;
    logic [KEY_BITS-1:0] kFlip;
    logic [SW_BITS-1:0]  sStable;
    logic [SW_BITS-1:0]  sFlip;

    // Status registers.
    logic kReady;
    logic kOverrun;
    logic kIe;
    logic sReady;
    logic sOverrun;
    logic sIe;

    // Address decode and strobes.
    logic kDataSel;
    logic sDataSel;
    logic kCtrlSel;
    logic sCtrlSel;
    logic kLoad;
    logic sLoad;
    logic kCtrlWr;
    logic sCtrlWr;
    logic kEvent;
    logic sEvent;

    // wr_data bits outside the control fields have no destination.
    logic unusedWrBits;
    assign unusedWrBits = ^{wr_data[DBITS-1:5], wr_data[3], wr_data[1:0]};

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        // Pushbuttons idle high, so their synchronizers reset to 1 and the
        // debounced state is inverted to read 1 = pressed.
        for (gi = 0; gi < KEY_BITS; gi++) begin : gKey
            key_sw_io_device_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_LEVEL     (1'b1),
                .INVERT          (1'b1)
            ) uDebounce (
                .clk    (clk),
                .reset  (reset),
                .rawIn  (KEY[gi]),
                .stable (kStable[gi]),
                .flip   (kFlip[gi])
            );
        end

        for (gi = 0; gi < SW_BITS; gi++) begin : gSw
            key_sw_io_device_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_LEVEL     (1'b0),
                .INVERT          (1'b0)
            ) uDebounce (
                .clk    (clk),
                .reset  (reset),
                .rawIn  (SW[gi]),
                .stable (sStable[gi]),
                .flip   (sFlip[gi])
            );
        end
    endgenerate

    // Several bits settling on the same edge form a single event.
    assign kEvent = |kFlip;
    assign sEvent = |sFlip;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    assign kDataSel = (addr == ADDR_KEY);
    assign sDataSel = (addr == ADDR_SW);
    assign kCtrlSel = (addr == ADDR_KCTRL);
    assign sCtrlSel = (addr == ADDR_SCTRL);

    assign kLoad   = rd_en & kDataSel;
    assign sLoad   = rd_en & sDataSel;
    assign kCtrlWr = wr_en & kCtrlSel;
    assign sCtrlWr = wr_en & sCtrlSel;

    // -----------------------------------------------------------------------
    // Status registers
    //
    // Ready: set by an event, cleared by a load of the data register; the
    // set wins when both happen on one edge.
    // Overrun: set by an event that finds Ready already high, except when
    // that same edge's load is consuming the previous value. A control
    // store with bit2 = 0 clears it; a coinciding set still wins.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kReady   <= 1'b0;
            kOverrun <= 1'b0;
            kIe      <= 1'b0;
        end else begin
            if (kEvent) begin
                kReady <= 1'b1;
            end else if (kLoad) begin
                kReady <= 1'b0;
            end

            if (kEvent && kReady && !kLoad) begin
                kOverrun <= 1'b1;
            end else if (kCtrlWr && !wr_data[2]) begin
                kOverrun <= 1'b0;
            end

            if (kCtrlWr) begin
                kIe <= wr_data[4];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sReady   <= 1'b0;
            sOverrun <= 1'b0;
            sIe      <= 1'b0;
        end else begin
            if (sEvent) begin
                sReady <= 1'b1;
            end else if (sLoad) begin
                sReady <= 1'b0;
            end

            if (sEvent && sReady && !sLoad) begin
                sOverrun <= 1'b1;
            end else if (sCtrlWr && !wr_data[2]) begin
                sOverrun <= 1'b0;
            end

            if (sCtrlWr) begin
                sIe <= wr_data[4];
            end
        end
    end

    assign irq = (kReady & kIe) | (sReady & sIe);

    // -----------------------------------------------------------------------
    // Read mux: driven from addr alone so the write-back stage can capture
    // it in the same cycle; rd_en only governs the side effects above.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        if (kDataSel) begin
            rd_data[KEY_BITS-1:0] = kStable;
        end else if (sDataSel) begin
            rd_data[SW_BITS-1:0] = sStable;
        end else if (kCtrlSel) begin
            rd_data[0] = kReady;
            rd_data[2] = kOverrun;
            rd_data[4] = kIe;
        end else if (sCtrlSel) begin
            rd_data[0] = sReady;
            rd_data[2] = sOverrun;
            rd_data[4] = sIe;
        end
    end

endmodule

// File: tb/tb_key_sw_io_device.sv
module tb_key_sw_io_device;

    localparam logic [31:0] A_KEY   = 32'hF000_0010;
    localparam logic [31:0] A_SW    = 32'hF000_0014;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;
    localparam logic [31:0] A_NONE  = 32'hF000_0018;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;
    logic        irq;

    int checks = 0;
    int fails  = 0;

    // Scoreboard: expected values are queued when stimulus is applied and
    // popped when the corresponding DUT output is sampled.
    logic [31:0] expQ[$];
    logic [31:0] expV;

    key_sw_io_device #(
        .DBITS           (32),
        .ADDR_KEY        (A_KEY),
        .ADDR_SW         (A_SW),
        .ADDR_KCTRL      (A_KCTRL),
        .ADDR_SCTRL      (A_SCTRL),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .KEY     (KEY),
        .SW      (SW),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Advance one clock edge; inputs change and outputs are sampled 1 time
    // unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Put an address on the bus without strobes and let rd_data settle.
    task automatic peek(input logic [31:0] a);
        addr  = a;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        tick();
        expQ.push_back(32'h0); expQ.push_back(32'h0);
        expQ.push_back(32'h0); expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        peek(A_KEY);   expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL reset_kdata got=%h exp=%h", rd_data, expV); end
        $display("[TB] reset kdata=%h", rd_data);
        peek(A_SW);    expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL reset_sdata got=%h exp=%h", rd_data, expV); end
        $display("[TB] reset sdata=%h", rd_data);
        peek(A_KCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL reset_kctrl got=%h exp=%h", rd_data, expV); end
        $display("[TB] reset kctrl=%h", rd_data);
        peek(A_SCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL reset_sctrl got=%h exp=%h", rd_data, expV); end
        $display("[TB] reset sctrl=%h", rd_data);
        expV = expQ.pop_front(); checks++;
        if ({31'b0, irq} !== expV) begin fails++; $display("FAIL reset_irq got=%b exp=%h", irq, expV); end
        $display("[TB] reset irq=%b", irq);
    endtask

    // KEY[0] pressed: stable must update on exactly the 6th edge.
    task automatic test_key_latency();
        KEY = 4'b1110;
        expQ.push_back(32'h0); expQ.push_back(32'h1);
        expQ.push_back(32'h1); expQ.push_back(32'h1);
        expQ.push_back(32'h0);
        ticks(5);
        peek(A_KEY); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL key_edge5 got=%h exp=%h", rd_data, expV); end
        $display("[TB] key after 5 edges kdata=%h", rd_data);
        tick();
        peek(A_KEY); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL key_edge6 got=%h exp=%h", rd_data, expV); end
        $display("[TB] key after 6 edges kdata=%h", rd_data);
        tick();
        peek(A_KCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL key_ready got=%h exp=%h", rd_data, expV); end
        $display("[TB] kctrl=%h", rd_data);
        addr = A_KEY; rd_en = 1'b1; #1;
        expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL key_load got=%h exp=%h", rd_data, expV); end
        $display("[TB] load kdata=%h", rd_data);
        tick();
        rd_en = 1'b0;
        peek(A_KCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL key_ready_clr got=%h exp=%h", rd_data, expV); end
        $display("[TB] kctrl after load=%h", rd_data);
    endtask

    // A 3-cycle pulse is shorter than the debounce window.
    task automatic test_glitch();
        SW = 10'h008;
        ticks(3);
        SW = 10'h000;
        expQ.push_back(32'h0); expQ.push_back(32'h0);
        ticks(10);
        peek(A_SW); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL glitch_sdata got=%h exp=%h", rd_data, expV); end
        $display("[TB] glitch sdata=%h", rd_data);
        peek(A_SCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL glitch_sctrl got=%h exp=%h", rd_data, expV); end
        $display("[TB] glitch sctrl=%h", rd_data);
    endtask

    task automatic test_overrun();
        SW = 10'h001;
        ticks(8);
        SW = 10'h003;
        ticks(8);
        expQ.push_back(32'h5); expQ.push_back(32'h1);
        expQ.push_back(32'h3); expQ.push_back(32'h0);
        peek(A_SCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL ovr_set got=%h exp=%h", rd_data, expV); end
        $display("[TB] overrun sctrl=%h", rd_data);
        store(A_SCTRL, 32'h0);
        peek(A_SCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL ovr_clr got=%h exp=%h", rd_data, expV); end
        $display("[TB] after store sctrl=%h", rd_data);
        addr = A_SW; rd_en = 1'b1; #1;
        expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL ovr_sdata got=%h exp=%h", rd_data, expV); end
        $display("[TB] load sdata=%h", rd_data);
        tick();
        rd_en = 1'b0;
        peek(A_SCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL ovr_ready_clr got=%h exp=%h", rd_data, expV); end
        $display("[TB] after load sctrl=%h", rd_data);
    endtask

    // Stores to a data register have no effect; unmapped address reads 0.
    task automatic test_data_write_ignored();
        store(A_KEY, 32'hFFFF_FFFF);
        expQ.push_back(32'h1); expQ.push_back(32'h0);
        peek(A_KEY); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL kdata_write got=%h exp=%h", rd_data, expV); end
        $display("[TB] kdata after store=%h", rd_data);
        peek(A_NONE); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL unmapped got=%h exp=%h", rd_data, expV); end
        $display("[TB] unmapped=%h", rd_data);
    endtask

    task automatic test_irq();
        store(A_KCTRL, 32'h10);
        KEY = 4'b1010;
        expQ.push_back(32'h0); expQ.push_back(32'h1);
        expQ.push_back(32'h5); expQ.push_back(32'h0);
        ticks(5);
        peek(A_KCTRL);
        expV = expQ.pop_front(); checks++;
        if ({31'b0, irq} !== expV) begin fails++; $display("FAIL irq_early got=%b exp=%h", irq, expV); end
        $display("[TB] irq before ready=%b", irq);
        tick();
        expV = expQ.pop_front(); checks++;
        if ({31'b0, irq} !== expV) begin fails++; $display("FAIL irq_rise got=%b exp=%h", irq, expV); end
        $display("[TB] irq after ready=%b", irq);
        addr = A_KEY; rd_en = 1'b1; #1;
        expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL irq_kdata got=%h exp=%h", rd_data, expV); end
        $display("[TB] irq load kdata=%h", rd_data);
        tick();
        rd_en = 1'b0;
        expV = expQ.pop_front(); checks++;
        if ({31'b0, irq} !== expV) begin fails++; $display("FAIL irq_fall got=%b exp=%h", irq, expV); end
        $display("[TB] irq after load=%b", irq);
    endtask

    // Event and data load land on the same edge.
    task automatic test_back_to_back();
        KEY = 4'b1000;
        ticks(8);
        KEY = 4'b1010;
        expQ.push_back(32'h7); expQ.push_back(32'h11);
        expQ.push_back(32'h5); expQ.push_back(32'h1);
        ticks(5);
        addr = A_KEY; rd_en = 1'b1; #1;
        expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL b2b_old got=%h exp=%h", rd_data, expV); end
        $display("[TB] b2b load kdata=%h", rd_data);
        tick();
        rd_en = 1'b0;
        peek(A_KCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL b2b_kctrl got=%h exp=%h", rd_data, expV); end
        $display("[TB] b2b kctrl=%h", rd_data);
        peek(A_KEY); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL b2b_new got=%h exp=%h", rd_data, expV); end
        $display("[TB] b2b kdata=%h", rd_data);
        expV = expQ.pop_front(); checks++;
        if ({31'b0, irq} !== expV) begin fails++; $display("FAIL b2b_irq got=%b exp=%h", irq, expV); end
        $display("[TB] b2b irq=%b", irq);
    endtask

    // Reset pulse while KEY is debouncing a release (counter at 2).
    task automatic test_reset_mid_debounce();
        KEY = 4'b1111;
        ticks(4);
        reset = 1'b0;
        expQ.push_back(32'h0); expQ.push_back(32'h0); expQ.push_back(32'h0);
        expQ.push_back(32'h0); expQ.push_back(32'h0);
        expQ.push_back(32'h3); expQ.push_back(32'h1);
        peek(A_KCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL rst_kctrl got=%h exp=%h", rd_data, expV); end
        $display("[TB] mid reset kctrl=%h", rd_data);
        peek(A_SW); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL rst_sdata got=%h exp=%h", rd_data, expV); end
        $display("[TB] mid reset sdata=%h", rd_data);
        expV = expQ.pop_front(); checks++;
        if ({31'b0, irq} !== expV) begin fails++; $display("FAIL rst_irq got=%b exp=%h", irq, expV); end
        $display("[TB] mid reset irq=%b", irq);
        tick();
        reset = 1'b1;
        ticks(10);
        peek(A_KCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL rst_no_event got=%h exp=%h", rd_data, expV); end
        $display("[TB] post reset kctrl=%h", rd_data);
        peek(A_KEY); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL rst_kdata got=%h exp=%h", rd_data, expV); end
        $display("[TB] post reset kdata=%h", rd_data);
        // SW was still 10'h003 across reset, so it re-debounces.
        peek(A_SW); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL rst_sw_redeb got=%h exp=%h", rd_data, expV); end
        $display("[TB] post reset sdata=%h", rd_data);
        peek(A_SCTRL); expV = expQ.pop_front(); checks++;
        if (rd_data !== expV) begin fails++; $display("FAIL rst_sw_ready got=%h exp=%h", rd_data, expV); end
        $display("[TB] post reset sctrl=%h", rd_data);
    endtask

    initial begin
        test_reset();
        test_key_latency();
        test_glitch();
        test_overrun();
        test_data_write_ignored();
        test_irq();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
